phimap_seq_ctrl: RTL and testbench

Time-multiplexed sequencer for the trigonometric functional-link expansion Phi(x). It accepts one input sample per transaction and steps one shared angle-map stage and one shared sin/cos LUT port through harmonics k = 1..(Q_ORD-1)/2. It then presents the packed Q_ORD-slot expansion through a valid/ready handshake. It replaces per-harmonic parallel angle-map/LUT instances in area-constrained HBOTFLAF builds.

---
 rtl/phimap_seq_ctrl_pkg.sv | 19 +
 rtl/phimap_seq_ctrl_if.sv | 11 +
 rtl/angle_map_pib2.sv | 14 +
 rtl/phimap_seq_ctrl.sv | 82 ++++++++
 tb/tb_phimap_seq_ctrl.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/phimap_seq_ctrl_pkg.sv
// phimap_seq_ctrl_pkg: shared state encoding and size/slot helpers for the Phi(x) sequencer
package phimap_seq_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;
    function automatic int nh(input int q);
        return (q - 1) / 2;
    endfunction
    function automatic int trunc_w(input int lw);
        return lw + 3;
    endfunction
    function automatic int sin_slot(input int k);
        return 2 * k - 1;
    endfunction
    function automatic int cos_slot(input int k);
        return 2 * k;
    endfunction
    function automatic bit q_ord_ok(input int q);
        return q >= 3 && q % 2 == 1;
    endfunction
endpackage

// File: rtl/phimap_seq_ctrl_if.sv
// phimap_seq_ctrl_if: sample-in / expansion-out handshakes plus the shared sin/cos LUT port
interface phimap_seq_ctrl_if #(parameter int Q_ORD = 7, parameter int WIDTH = 16, parameter int LUT_WIDTH = 7);
    logic in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] x_in, lut_sin, lut_cos;
    logic [LUT_WIDTH-1:0] lut_addr;
    logic [Q_ORD*WIDTH-1:0] nonl_x_out_packed;
    modport master(output in_valid, x_in, out_ready, lut_sin, lut_cos,
                   input in_ready, out_valid, lut_addr, nonl_x_out_packed);
    modport slave(input in_valid, x_in, out_ready, lut_sin, lut_cos,
                  output in_ready, out_valid, lut_addr, nonl_x_out_packed);
endinterface

// File: rtl/angle_map_pib2.sv
// angle_map_pib2: folds an angle (LUT_WIDTH fractional bits, units of pi) onto a half-wave |sin|/|cos| LUT address plus signs
module angle_map_pib2 #(parameter int LUT_WIDTH = 7, parameter int TRUNC_WIDTH = 10) (
    input  logic [TRUNC_WIDTH-1:0] x_trunc,
    output logic [LUT_WIDTH-1:0]   x_map,
    output logic                   sign_sin,
    output logic                   sign_cos
);
    logic unused_turns;
    assign x_map = x_trunc[LUT_WIDTH-1:0];
    // odd half-period flips both; cos also flips in the upper quarter of each half-period
    assign sign_sin = x_trunc[LUT_WIDTH];
    assign sign_cos = x_trunc[LUT_WIDTH] ^ x_trunc[LUT_WIDTH-1];
    assign unused_turns = ^x_trunc[TRUNC_WIDTH-1:LUT_WIDTH+1];
endmodule

// File: rtl/phimap_seq_ctrl.sv
// phimap_seq_ctrl: time-multiplexed sin/cos harmonic expansion through one angle map and one LUT port
module phimap_seq_ctrl
    import phimap_seq_ctrl_pkg::*;
#(
    parameter int Q_ORD = 7,
    parameter int WIDTH = 16,
    parameter int QP = 12,
    parameter int LUT_WIDTH = 7
) (
    input logic clk,
    input logic reset,
    phimap_seq_ctrl_if.slave io
);
    localparam int NH = nh(Q_ORD);
    localparam int TW = trunc_w(LUT_WIDTH);
    localparam int SH = QP - LUT_WIDTH;
    localparam int KW = $clog2(NH + 1);
    if (!q_ord_ok(Q_ORD)) begin : g_bad_q_ord
        $error("Q_ORD must be odd and >= 3");
    end
    state_t state;
    logic [WIDTH-1:0] x_r;
    logic [TW-1:0] xt_r, acc, x_trunc;
    logic [KW-1:0] k, k_d;
    logic [LUT_WIDTH-1:0] x_map;
    logic cap, ss, sc, ss_d, sc_d, last, accept;
    function automatic logic [WIDTH-1:0] half_signed(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -(v >> 1) : v >> 1;
    endfunction
    assign io.in_ready = state == IDLE || (state == HOLD && io.out_ready);
    assign accept = io.in_valid && io.in_ready;
    assign x_trunc = TW'((io.x_in + WIDTH'(1 << (SH - 1))) >> SH);
    assign last = k == KW'(NH);
    assign io.lut_addr = x_map;
    angle_map_pib2 #(.LUT_WIDTH(LUT_WIDTH), .TRUNC_WIDTH(TW)) u_map (
        .x_trunc(acc), .x_map(x_map), .sign_sin(ss), .sign_cos(sc)
    );
    // acc is frozen after the last issue so lut_addr holds its final value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            x_r <= '0;
            xt_r <= '0;
            acc <= '0;
            k <= '0;
            k_d <= '0;
            cap <= 1'b0;
            ss_d <= 1'b0;
            sc_d <= 1'b0;
            io.out_valid <= 1'b0;
            io.nonl_x_out_packed <= '0;
        end else begin
            cap <= state == ISSUE;
            ss_d <= ss;
            sc_d <= sc;
            k_d <= k;
            if (cap) begin
                io.nonl_x_out_packed[0 +: WIDTH] <= x_r;
                io.nonl_x_out_packed[sin_slot(int'(k_d))*WIDTH +: WIDTH] <= half_signed(io.lut_sin, ss_d);
                io.nonl_x_out_packed[cos_slot(int'(k_d))*WIDTH +: WIDTH] <= half_signed(io.lut_cos, sc_d);
            end
            if (accept) begin
                x_r <= io.x_in;
                xt_r <= x_trunc;
                acc <= x_trunc;
                k <= KW'(1);
                io.out_valid <= 1'b0;
                state <= ISSUE;
            end else if (state == ISSUE) begin
                acc <= last ? acc : acc + xt_r;
                k <= last ? k : k + 1'b1;
                state <= last ? DRAIN : ISSUE;
            end else if (state == DRAIN) begin
                io.out_valid <= 1'b1;
                state <= HOLD;
            end else if (state == HOLD && io.out_ready) begin
                io.out_valid <= 1'b0;
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_phimap_seq_ctrl.sv
// tb_phimap_seq_ctrl: directed checks of the Phi(x) sequencer against a bench-side truncate/accumulate/fold model
module tb_phimap_seq_ctrl;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int failures = 0;
    phimap_seq_ctrl_if #(.Q_ORD(7), .WIDTH(16), .LUT_WIDTH(7)) io();
    phimap_seq_ctrl #(.Q_ORD(7), .WIDTH(16), .QP(12), .LUT_WIDTH(7)) dut (.clk(clk), .reset(reset), .io(io));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        io.lut_sin <= {1'b0, io.lut_addr, 8'h00};
        io.lut_cos <= 16'hFF00 - {1'b0, io.lut_addr, 8'h00};
    end
    function automatic logic [9:0] m_trunc(input logic [15:0] x);
        logic [15:0] r;
        r = x + 16'd16;
        return r[14:5];
    endfunction
    function automatic logic [9:0] m_acc(input logic [15:0] x, input int k);
        return 10'(m_trunc(x) * k);
    endfunction
    function automatic logic [6:0] m_addr(input logic [15:0] x, input int k);
        logic [9:0] a;
        a = m_acc(x, k);
        return a[6:0];
    endfunction
    function automatic logic [15:0] m_half(input logic [15:0] v, input logic neg);
        logic [15:0] h;
        h = v >> 1;
        return neg ? 16'(0 - h) : h;
    endfunction
    function automatic logic [111:0] m_packed(input logic [15:0] x);
        logic [111:0] p;
        logic [9:0] a;
        logic [15:0] s;
        p = '0;
        p[15:0] = x;
        for (int k = 1; k <= 3; k++) begin
            a = m_acc(x, k);
            s = {1'b0, a[6:0], 8'h00};
            p[(2*k-1)*16 +: 16] = m_half(s, a[7]);
            p[(2*k)*16 +: 16] = m_half(16'hFF00 - s, a[7] ^ a[6]);
        end
        return p;
    endfunction
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [15:0] x);
        int n = 0;
        while (!io.in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("send_ready", io.in_ready, 1);
        io.in_valid = 1'b1;
        io.x_in = x;
        tick();
        io.in_valid = 1'b0;
    endtask
    task automatic run_txn(input logic [15:0] x);
        send(x);
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("lut_addr_k%0d", k), io.lut_addr, m_addr(x, k));
            tick();
        end
        chk("drain_valid", io.out_valid, 0);
        tick();
        chk("hold_valid", io.out_valid, 1);
        chk("packed", io.nonl_x_out_packed, m_packed(x));
    endtask
    task automatic release_hold();
        io.out_ready = 1'b1;
        tick();
        io.out_ready = 1'b0;
    endtask
    initial begin
        logic [15:0] s[4];
        int acc_i, out_i, last;
        reset = 1'b0;
        io.in_valid = 1'b0;
        io.x_in = '0;
        io.out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", io.out_valid, 0);
        chk("rst_packed", io.nonl_x_out_packed, 0);
        chk("rst_lut_addr", io.lut_addr, 0);
        chk("rst_in_ready", io.in_ready, 1);
        reset = 1'b1;
        tick();
        run_txn(16'h0000);
        chk("zero_hand", io.nonl_x_out_packed, {16'h7F80, 16'h0000, 16'h7F80, 16'h0000, 16'h7F80, 16'h0000, 16'h0000});
        release_hold();
        run_txn(16'h0800);
        chk("half_hand", io.nonl_x_out_packed, {16'h5F80, 16'hE000, 16'h8080, 16'h0000, 16'hA080, 16'h2000, 16'h0800});
        for (int c = 0; c < 10; c++) begin
            io.in_valid = 1'b1;
            io.x_in = 16'h1234;
            chk("bp_packed", io.nonl_x_out_packed, m_packed(16'h0800));
            chk("bp_valid", io.out_valid, 1);
            chk("bp_in_ready", io.in_ready, 0);
            tick();
        end
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", io.in_ready, 1);
        tick();
        chk("bp_idle_valid", io.out_valid, 0);
        io.out_ready = 1'b0;
        run_txn(16'h7FFF);
        chk("wrap_no_x", $isunknown(io.nonl_x_out_packed), 0);
        release_hold();
        send(16'h0123);
        tick();
        reset = 1'b0;
        #1;
        chk("abort_valid", io.out_valid, 0);
        chk("abort_packed", io.nonl_x_out_packed, 0);
        chk("abort_lut_addr", io.lut_addr, 0);
        chk("abort_in_ready", io.in_ready, 1);
        tick();
        reset = 1'b1;
        tick();
        run_txn(16'h0400);
        release_hold();
        s = '{16'h0800, 16'hF800, 16'h1234, 16'h4C00};
        acc_i = 0;
        out_i = 0;
        last = -1;
        io.out_ready = 1'b1;
        for (int c = 0; c < 40 && out_i < 4; c++) begin
            io.in_valid = acc_i < 4;
            io.x_in = acc_i < 4 ? s[acc_i] : 16'h0000;
            if (io.out_valid) begin
                chk($sformatf("b2b_packed%0d", out_i), io.nonl_x_out_packed, m_packed(s[out_i]));
                if (last >= 0) chk("b2b_interval", c - last, 5);
                last = c;
                out_i++;
            end
            if (io.in_valid && io.in_ready) acc_i++;
            tick();
        end
        io.in_valid = 1'b0;
        chk("b2b_count", out_i, 4);
        chk("b2b_accepted", acc_i, 4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
